// File: rtl/snake_pkg.sv
// Shared snake types: game mode, move direction, round-sequencer state and helpers.
// Pure declarations; no logic, so no latency or backpressure of its own.
package snake_pkg;

    typedef enum logic [1:0] {
        MENU  = 2'd0,
        GAME  = 2'd1,
        SCORE = 2'd2
    } game_mode;

    // Encoding puts opposites two apart so a reversal is a single bit flip.
    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } direction;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_DIR = 3'd1,
        MOVE     = 3'd2,
        COLLIDE  = 3'd3,
        POINT    = 3'd4,
        RESOLVE  = 3'd5,
        OVER     = 3'd6
    } round_state_e;

    localparam int MAX_PLAYERS = 8;

    function automatic direction opposite(input direction d);
        return direction'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/dir_latch.sv
// Per-player pending direction with reversal filter and a "got one this round" flag.
// Updates one cycle after the strobe; never stalls, a consume in the same cycle as a strobe keeps the flag.
module dir_latch
    import snake_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     clear,
    input  logic     consume,
    input  logic     vld,
    input  direction dir,
    input  direction cur,
    input  logic     alive,
    output direction pending,
    output logic     got
);

    direction ref_dir;
    logic     accept;

    // When the pending value is being committed this cycle it becomes the new
    // heading, so a same-cycle strobe must be filtered against it instead.
    always_comb begin
        ref_dir = consume ? pending : cur;
        accept  = vld && alive;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= RIGHT;
            got     <= 1'b0;
        end else if (clear) begin
            pending <= RIGHT;
            got     <= 1'b0;
        end else if (accept) begin
            got <= 1'b1;
            if (dir != opposite(ref_dir)) begin
                pending <= dir;
            end
        end else if (consume) begin
            got <= 1'b0;
        end
    end

endmodule

// File: rtl/round_seq.sv
// Per-tick game round controller: gather directions, then move -> collide -> point, then resolve result.
// Tick to move_start is 2 cycles when directions are in; each done pulse yields the next strobe 1 cycle later.
module round_seq
    import snake_pkg::*;
#(
    parameter int                     NUM_PLAYERS = 2,
    parameter int                     LOCAL_ID    = 0,
    parameter logic [NUM_PLAYERS-1:0] REMOTE_MASK = 'b10,
    parameter int unsigned            DIR_TIMEOUT = 1_000_000,
    parameter int                     RND_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  game_mode               mode,
    input  logic                   tick,
    input  direction               dir_in [NUM_PLAYERS],
    input  logic [NUM_PLAYERS-1:0] dir_valid,
    output direction               dir_out [NUM_PLAYERS],
    output logic                   move_start,
    output logic                   coll_start,
    output logic                   point_start,
    input  logic                   move_done,
    input  logic                   coll_done,
    input  logic                   point_done,
    input  logic [NUM_PLAYERS-1:0] alive_in,
    output logic [NUM_PLAYERS-1:0] alive,
    output logic                   won,
    output logic                   lost,
    output logic                   draw,
    output logic                   con_error,
    output logic                   tick_overrun,
    output logic [RND_W-1:0]       round_cnt
);

    localparam int TW = (DIR_TIMEOUT < 1) ? 1 : $clog2(DIR_TIMEOUT + 1);
    localparam logic [NUM_PLAYERS-1:0] OTHERS = ~(NUM_PLAYERS'(1) << LOCAL_ID);

    round_state_e           state;
    game_mode               mode_q;
    logic [TW-1:0]          timer;
    direction               pending [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] got;
    logic [NUM_PLAYERS-1:0] required;
    logic                   in_game;
    logic                   game_start;
    logic                   covered;
    logic                   copy;
    logic                   l_alive;
    logic                   o_alive;

    always_comb begin
        in_game    = (mode == GAME);
        game_start = in_game && (mode_q != GAME);
        required   = REMOTE_MASK & alive;
        covered    = ((got & required) == required);
        copy       = in_game && !game_start && (state == WAIT_DIR) && covered;
        l_alive    = alive[LOCAL_ID];
        o_alive    = |(alive & OTHERS);
    end

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_lat
        dir_latch u_lat (
            .clk     (clk),
            .rst     (rst),
            .clear   (game_start),
            .consume (copy),
            .vld     (dir_valid[i]),
            .dir     (dir_in[i]),
            .cur     (dir_out[i]),
            .alive   (alive[i]),
            .pending (pending[i]),
            .got     (got[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            mode_q       <= MENU;
            timer        <= '0;
            move_start   <= 1'b0;
            coll_start   <= 1'b0;
            point_start  <= 1'b0;
            tick_overrun <= 1'b0;
            alive        <= '1;
            won          <= 1'b0;
            lost         <= 1'b0;
            draw         <= 1'b0;
            con_error    <= 1'b0;
            round_cnt    <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) dir_out[i] <= RIGHT;
        end else begin
            mode_q       <= mode;
            move_start   <= 1'b0;
            coll_start   <= 1'b0;
            point_start  <= 1'b0;
            tick_overrun <= 1'b0;

            if (game_start) begin
                state     <= IDLE;
                timer     <= '0;
                alive     <= '1;
                won       <= 1'b0;
                lost      <= 1'b0;
                draw      <= 1'b0;
                con_error <= 1'b0;
                round_cnt <= '0;
                for (int i = 0; i < NUM_PLAYERS; i++) dir_out[i] <= RIGHT;
            end else if (!in_game) begin
                // Leaving the game aborts the round silently; results stay visible.
                state <= IDLE;
            end else begin
                if (tick && state != IDLE) tick_overrun <= 1'b1;

                case (state)
                    IDLE: begin
                        if (tick) begin
                            state <= WAIT_DIR;
                            timer <= TW'(DIR_TIMEOUT);
                        end
                    end
                    WAIT_DIR: begin
                        if (copy) begin
                            for (int i = 0; i < NUM_PLAYERS; i++) dir_out[i] <= pending[i];
                            move_start <= 1'b1;
                            state      <= MOVE;
                        end else if (timer == '0) begin
                            con_error <= 1'b1;
                            state     <= OVER;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    MOVE: begin
                        if (move_done) begin
                            coll_start <= 1'b1;
                            state      <= COLLIDE;
                        end
                    end
                    COLLIDE: begin
                        if (coll_done) begin
                            alive       <= alive & alive_in;
                            point_start <= 1'b1;
                            state       <= POINT;
                        end
                    end
                    POINT: begin
                        if (point_done) state <= RESOLVE;
                    end
                    RESOLVE: begin
                        if (round_cnt != {RND_W{1'b1}}) round_cnt <= round_cnt + 1'b1;
                        if (!l_alive && !o_alive) begin
                            draw  <= 1'b1;
                            state <= OVER;
                        end else if (l_alive && !o_alive) begin
                            won   <= 1'b1;
                            state <= OVER;
                        end else if (!l_alive) begin
                            lost  <= 1'b1;
                            state <= OVER;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    OVER: begin
                        state <= OVER;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
